multicycle_main_fsm: RTL and testbench
======================================

Name: multicycle_main_fsm

Overview:
- Moore main state machine of the multi-cycle controller. Sits directly upstream of the datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback cycles.
- Drives the datapath select lines: AdrSrc, ALUSrcA, ALUSrcB, ResultSrc.
- Drives the raw write strobes (IRWrite, NextPC, RegW, MemW, Branch) and ALUOp. The condition-check logic gates the strobes into PCWrite, RegWrite and MemWrite.

Parameters:
- UNKNOWN_TRAP, 0, 0: UNKNOWN state returns to FETCH after one cycle. 1: UNKNOWN holds until reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- Op  input  2  Instr[27:26] from instruction register.
- Funct  input  6  Instr[25:20]. Funct[5] = I bit; Funct[0] = L/S bit.
- IRWrite  output  1  load instruction register.
- AdrSrc  output  1  0 = PC, 1 = Result as memory address.
- ALUSrcA  output  1  0 = A register, 1 = PC.
- ALUSrcB  output  2  00 = WriteData, 01 = ExtImm, 10 = constant 4.
- ResultSrc  output  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- NextPC  output  1  PC update request.
- RegW  output  1  register write request.
- MemW  output  1  memory write request.
- Branch  output  1  branch request (condition-gated downstream into PC write).
- ALUOp  output  1  1 = ALU decoder uses Funct; 0 = add.
- state  output  4  current state encoding, debug/verification.

Behaviour:
- State encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5
  - EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, UNKNOWN=10
- Reset:
  - reset=0 asynchronously forces state=FETCH.
  - While reset=0, outputs are IRWrite=0, NextPC=0, RegW=0, MemW=0, Branch=0, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUOp=0, state=0.
  - The first rising edge after reset releases performs FETCH.
- Transitions, one per rising edge:
  - FETCH -> DECODE.
  - DECODE, Op=01 -> MEMADR.
  - DECODE, Op=00 & Funct[5]=0 -> EXECUTER.
  - DECODE, Op=00 & Funct[5]=1 -> EXECUTEI.
  - DECODE, Op=10 -> BRANCH.
  - DECODE, Op=11 -> UNKNOWN.
  - MEMADR, Funct[0]=1 -> MEMREAD; Funct[0]=0 -> MEMWRITE.
  - MEMREAD -> MEMWB -> FETCH.
  - MEMWRITE -> FETCH.
  - EXECUTER or EXECUTEI -> ALUWB -> FETCH.
  - BRANCH -> FETCH.
  - UNKNOWN -> FETCH if UNKNOWN_TRAP=0, else stays in UNKNOWN.
  - Encodings 11-15 -> FETCH on the next edge; all outputs 0 while in them.
- Outputs are a pure function of state (Moore). Unlisted outputs are 0.
  - FETCH: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10 (presents PC+8 as R15).
  - MEMADR: ALUSrcA=0, ALUSrcB=01, ALUOp=0.
  - MEMREAD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemW=1.
  - EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUOp=1.
  - EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, ALUOp=0, Branch=1.
  - UNKNOWN: all 0.
- Op and Funct are sampled only in DECODE and MEMADR. They come from the IR, which loads only in FETCH, so they are stable.
- Latency per instruction class:
  - LDR: 5 cycles.
  - STR: 4 cycles.
  - Data-processing: 4 cycles.
  - Branch: 3 cycles.
  - Unknown (TRAP=0): 3 cycles.
- Reset asserted mid-instruction (any state): state returns to FETCH immediately and write strobes drop in the same cycle, with no edge needed. A pending MemW or RegW is never issued.
- No other outputs are registered. All strobes are glitch-free relative to clk because they decode registered state.

Test Plan:
- Hold reset=0 for 3 cycles, release. Required: state=0 and IRWrite=0 during reset; IRWrite=1 and NextPC=1 in the first cycle after release; state=1 next.
- Op=01, Funct=011001 (LDR). Required: state sequence 0,1,2,3,4,0; RegW=1 only in state 4 with ResultSrc=01; AdrSrc=1 in state 3.
- Op=01, Funct=011000 (STR). Required: states 0,1,2,5,0; MemW=1 exactly one cycle, in state 5, with AdrSrc=1.
- Op=00, Funct=101000 (ADD imm), then Funct=001000 (ADD reg). Required: states 0,1,7,8,0 with ALUSrcB=01, then 0,1,6,8,0 with ALUSrcB=00; ALUOp=1 in the execute state.
- Op=10 (B). Required: states 0,1,9,0; Branch=1, ALUSrcB=01, ResultSrc=10 in state 9. Op=11 with TRAP=0: states 0,1,10,0. Same with TRAP=1: state holds at 10 for 20 cycles until reset.
- Assert reset while in MEMWRITE (state 5), asynchronously between edges. Required: MemW falls to 0 before the next edge; state=0; normal fetch resumes after release.

Source files
------------

// File: rtl/multicycle_main_fsm_if.sv
// Control bundle between the multi-cycle main FSM and the datapath/condition logic.
// Op/Funct come from the instruction register; everything else is driven by the FSM.
interface multicycle_main_fsm_if;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       IRWrite;
    logic       AdrSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic       Branch;
    logic       ALUOp;
    logic [3:0] state;

    modport master (
        input  Op, Funct,
        output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
               NextPC, RegW, MemW, Branch, ALUOp, state
    );

    modport slave (
        output Op, Funct,
        input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
               NextPC, RegW, MemW, Branch, ALUOp, state
    );
endinterface

// File: rtl/multicycle_main_fsm.sv
// Moore main controller of the multi-cycle core: fetch/decode/execute/memory/writeback
// sequencing, datapath select lines and raw write strobes decoded from registered state.
module multicycle_main_fsm #(
    parameter bit UNKNOWN_TRAP = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_main_fsm_if.master   bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_UNKNOWN  = 4'd10
    } state_e;

    state_e state_q, state_d;

    logic       ir_write, adr_src, alu_src_a, next_pc, reg_w, mem_w, branch, alu_op;
    logic [1:0] alu_src_b, result_src;

    // Only I (bit 5) and L/S (bit 0) steer the sequence; the rest belongs to the ALU decoder.
    logic unused_funct;
    assign unused_funct = ^bus.Funct[4:1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (bus.Op)
                    2'b00:   state_d = bus.Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_UNKNOWN;
                endcase
            end
            S_MEMADR:   state_d = bus.Funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = S_FETCH;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_UNKNOWN:  state_d = UNKNOWN_TRAP ? S_UNKNOWN : S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        ir_write   = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        next_pc    = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        branch     = 1'b0;
        alu_op     = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write   = 1'b1;
                next_pc    = 1'b1;
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            S_DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            S_MEMADR:  alu_src_b = 2'b01;
            S_MEMREAD: adr_src   = 1'b1;
            S_MEMWB: begin
                result_src = 2'b01;
                reg_w      = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src = 1'b1;
                mem_w   = 1'b1;
            end
            S_EXECUTER: alu_op = 1'b1;
            S_EXECUTEI: begin
                alu_src_b = 2'b01;
                alu_op    = 1'b1;
            end
            S_ALUWB: reg_w = 1'b1;
            S_BRANCH: begin
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                branch     = 1'b1;
            end
            default: ;
        endcase
        // Reset already parks state in FETCH; just hold off the fetch strobes until release.
        if (!reset) begin
            ir_write = 1'b0;
            next_pc  = 1'b0;
        end
    end

    assign bus.IRWrite   = ir_write;
    assign bus.AdrSrc    = adr_src;
    assign bus.ALUSrcA   = alu_src_a;
    assign bus.ALUSrcB   = alu_src_b;
    assign bus.ResultSrc = result_src;
    assign bus.NextPC    = next_pc;
    assign bus.RegW      = reg_w;
    assign bus.MemW      = mem_w;
    assign bus.Branch    = branch;
    assign bus.ALUOp     = alu_op;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Randomized instruction stream checked against a per-class state-sequence model and
// a per-state output table; second instance covers the trapping UNKNOWN variant.
module tb_multicycle_main_fsm;

    logic clk = 1'b0;
    logic rst0_n, rst1_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    multicycle_main_fsm_if bus0 ();
    multicycle_main_fsm_if bus1 ();

    multicycle_main_fsm #(.UNKNOWN_TRAP(1'b0)) u_dut0 (.clk(clk), .reset(rst0_n), .bus(bus0));
    multicycle_main_fsm #(.UNKNOWN_TRAP(1'b1)) u_dut1 (.clk(clk), .reset(rst1_n), .bus(bus1));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW, Branch, ALUOp}
    function automatic logic [11:0] mk(input logic ir, adr, a, input logic [1:0] b, r,
                                       input logic npc, rw, mw, br, op);
        return {ir, adr, a, b, r, npc, rw, mw, br, op};
    endfunction

    function automatic logic [11:0] exp_out(input int st);
        case (st)
            0:  return mk(1, 0, 1, 2'b10, 2'b10, 1, 0, 0, 0, 0);
            1:  return mk(0, 0, 1, 2'b10, 2'b10, 0, 0, 0, 0, 0);
            2:  return mk(0, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0);
            3:  return mk(0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
            4:  return mk(0, 0, 0, 2'b00, 2'b01, 0, 1, 0, 0, 0);
            5:  return mk(0, 1, 0, 2'b00, 2'b00, 0, 0, 1, 0, 0);
            6:  return mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1);
            7:  return mk(0, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0, 1);
            8:  return mk(0, 0, 0, 2'b00, 2'b00, 0, 1, 0, 0, 0);
            9:  return mk(0, 0, 0, 2'b01, 2'b10, 0, 0, 0, 1, 0);
            default: return 12'h000;
        endcase
    endfunction

    function automatic logic [11:0] reset_out();
        return mk(0, 0, 1, 2'b10, 2'b10, 0, 0, 0, 0, 0);
    endfunction

    function automatic logic [11:0] pack0();
        return {bus0.IRWrite, bus0.AdrSrc, bus0.ALUSrcA, bus0.ALUSrcB, bus0.ResultSrc,
                bus0.NextPC, bus0.RegW, bus0.MemW, bus0.Branch, bus0.ALUOp};
    endfunction

    function automatic logic [11:0] pack1();
        return {bus1.IRWrite, bus1.AdrSrc, bus1.ALUSrcA, bus1.ALUSrcB, bus1.ResultSrc,
                bus1.NextPC, bus1.RegW, bus1.MemW, bus1.Branch, bus1.ALUOp};
    endfunction

    // Instruction class -> visited states, FETCH first; return to FETCH is implied.
    task automatic build_seq(input logic [1:0] op, input logic [5:0] fn, output int seq[$]);
        seq = {0, 1};
        case (op)
            2'b01:   seq = fn[0] ? {seq, 2, 3, 4} : {seq, 2, 5};
            2'b00:   seq = {seq, (fn[5] ? 7 : 6), 8};
            2'b10:   seq = {seq, 9};
            default: seq = {seq, 10};
        endcase
    endtask

    task automatic run_instr(input string name, input logic [1:0] op, input logic [5:0] fn);
        int seq[$];
        build_seq(op, fn, seq);
        bus0.Op    = op;
        bus0.Funct = fn;
        foreach (seq[i]) begin
            chk($sformatf("%s.st%0d", name, i), 32'(bus0.state), 32'(seq[i]));
            chk($sformatf("%s.out%0d", name, i), 32'(pack0()), 32'(exp_out(seq[i])));
            @(negedge clk);
        end
        chk($sformatf("%s.ret", name), 32'(bus0.state), 32'd0);
    endtask

    initial begin
        logic [1:0] op;
        logic [5:0] fn;
        rst0_n = 1'b0;
        rst1_n = 1'b0;
        bus0.Op = 2'b00; bus0.Funct = 6'd0;
        bus1.Op = 2'b11; bus1.Funct = 6'd0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst.state", 32'(bus0.state), 32'd0);
            chk("rst.out", 32'(pack0()), 32'(reset_out()));
        end
        rst0_n = 1'b1;
        #1;
        chk("rel.irw", 32'(bus0.IRWrite), 32'd1);
        chk("rel.npc", 32'(bus0.NextPC), 32'd1);
        @(negedge clk);
        chk("rel.next", 32'(bus0.state), 32'd1);
        // one edge later DECODE (Op=00 reg) -> EXECUTER -> ALUWB -> FETCH
        repeat (3) @(negedge clk);
        chk("rel.fetch", 32'(bus0.state), 32'd0);

        run_instr("ldr",  2'b01, 6'b011001);
        run_instr("str",  2'b01, 6'b011000);
        run_instr("addi", 2'b00, 6'b101000);
        run_instr("addr", 2'b00, 6'b001000);
        run_instr("b",    2'b10, 6'b000000);
        run_instr("unk",  2'b11, 6'b000000);

        for (int n = 0; n < 60; n++) begin
            op = 2'($urandom_range(0, 3));
            fn = 6'($urandom);
            run_instr($sformatf("rnd%0d", n), op, fn);
        end

        // Reset between edges while a store is on the bus.
        bus0.Op = 2'b01; bus0.Funct = 6'b011000;
        repeat (3) @(negedge clk);
        chk("mid.st5", 32'(bus0.state), 32'd5);
        chk("mid.memw", 32'(bus0.MemW), 32'd1);
        #2 rst0_n = 1'b0;
        #1;
        chk("mid.memw_drop", 32'(bus0.MemW), 32'd0);
        chk("mid.state", 32'(bus0.state), 32'd0);
        chk("mid.out", 32'(pack0()), 32'(reset_out()));
        @(negedge clk);
        chk("mid.hold", 32'(bus0.state), 32'd0);
        rst0_n = 1'b1;
        #1;
        run_instr("resume", 2'b01, 6'b011001);

        // Trapping instance: UNKNOWN holds until reset.
        @(negedge clk);
        rst1_n = 1'b1;
        #1;
        chk("trap.st0", 32'(bus1.state), 32'd0);
        @(negedge clk);
        chk("trap.st1", 32'(bus1.state), 32'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("trap.hold%0d", i), 32'(bus1.state), 32'd10);
            chk($sformatf("trap.out%0d", i), 32'(pack1()), 32'd0);
        end
        rst1_n = 1'b0;
        #1;
        chk("trap.rst", 32'(bus1.state), 32'd0);
        chk("trap.rst_out", 32'(pack1()), 32'(reset_out()));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
